// File: rtl/regfile_sb.sv
// regfile_sb: register file with an integrated write-back scoreboard.
//
// The file has NRD combinational read ports with same-cycle write-to-read
// bypass and one write port. Each register also has a saturating counter
// of issued but not yet written-back instructions. Decode uses rd_busy
// and iss_ready to detect RAW hazards. Register 0 always reads as zero.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   rd_addr/data   NRD read ports, port k packed at [k*W +: W]
//   rd_busy        per port: a write to that register is still pending
//   iss_en/addr    decode issues an instruction that writes iss_addr
//   iss_ready      the issue is accepted this cycle
//   wr_en/addr/data  write-back port
//   wr_pc          PC of the writing instruction (used only for tracing)
//   flush          clears all counters at the edge
//   err_underflow  sticky flag: a write-back arrived while the counter was 0
//
// Build option: define RF_TRACE_EN to print one simulation line per
// accepted write, flush or underflow. If it is undefined, the module
// prints nothing.

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_ready,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [31:0]             wr_pc,
  input  logic                    flush,
  output logic                    err_underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [CNT_W-1:0]  cnt_reg  [DEPTH];
  logic [CNT_W-1:0]  cnt_next [DEPTH];
  logic              err_reg;

  // A write to r0 is ignored completely. It does not change a counter and
  // it does not raise an error.
  logic wr_live;
  logic iss_fire;
  logic underflow_now;

  assign wr_live = wr_en && (wr_addr != '0);

  // An issue is refused only when its counter is saturated. A write-back
  // to the same register in the same cycle frees one slot.
  assign iss_ready = !((iss_addr != '0) && (cnt_reg[iss_addr] == CNT_MAX) &&
                       !(wr_live && (wr_addr == iss_addr)));
  assign iss_fire  = iss_en && iss_ready && (iss_addr != '0);

  // A same-cycle issue to the same register means the write consumes that
  // issue, so this case is not an underflow.
  assign underflow_now = wr_live && (cnt_reg[wr_addr] == '0) &&
                         !(iss_fire && (iss_addr == wr_addr));

  assign err_underflow = err_reg;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      logic inc;
      logic hit;
      inc = iss_fire && (iss_addr == ADDR_W'(r));
      hit = wr_live && (wr_addr == ADDR_W'(r));
      cnt_next[r] = cnt_reg[r];
      if (flush)
        cnt_next[r] = '0;
      else if (inc && !hit)
        cnt_next[r] = cnt_reg[r] + CNT_ONE;
      else if (hit && !inc && (cnt_reg[r] != '0))
        cnt_next[r] = cnt_reg[r] - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_reg[r] <= '0;
        cnt_reg[r]  <= '0;
      end
      err_reg <= 1'b0;
    end else begin
      if (wr_live)
        regs_reg[wr_addr] <= wr_data;
      for (int r = 0; r < DEPTH; r++)
        cnt_reg[r] <= cnt_next[r];
      if (underflow_now)
        err_reg <= 1'b1;
    end
  end

  // Read ports. All outputs are forced to zero during reset, including any
  // value that wr_data would otherwise bypass onto rd_data.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              wr_hit;
      assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
      assign wr_hit = wr_en && (wr_addr == addr);

      assign rd_data[gi*DATA_W +: DATA_W] =
          (!reset_n || (addr == '0)) ? '0 :
          wr_hit                     ? wr_data :
                                       regs_reg[addr];

      // Busy means a write is still pending after this cycle. When this
      // cycle's write retires the last outstanding one, the port is free.
      assign rd_busy[gi] = reset_n && (addr != '0) && (cnt_reg[addr] != '0) &&
                           !(wr_hit && (cnt_reg[addr] == CNT_ONE));
    end
  endgenerate

`ifdef RF_TRACE_EN
  always @(posedge clk) begin
    if (reset_n) begin
      if (wr_live)
        $display("@%h: $%0d <= %h", wr_pc, wr_addr, wr_data);
      if (flush)
        $display("flush");
      if (underflow_now)
        $display("underflow $%0d", wr_addr);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int CNT_W  = 2;
  localparam int DEPTH  = 32;
  localparam int MAXC   = 3;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NRD*ADDR_W-1:0] rd_addr = '0;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en = 1'b0;
  logic [ADDR_W-1:0]     iss_addr = '0;
  logic                  iss_ready;
  logic                  wr_en = 1'b0;
  logic [ADDR_W-1:0]     wr_addr = '0;
  logic [DATA_W-1:0]     wr_data = '0;
  logic [31:0]           wr_pc = '0;
  logic                  flush = 1'b0;
  logic                  err_underflow;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .flush(flush), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Reference model: architectural register values, the number of
  // outstanding writes per register and the sticky error flag.
  logic [31:0] m_regs [DEPTH];
  int          m_cnt  [DEPTH];
  bit          m_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  // One clock cycle: drive the inputs, check the combinational outputs
  // against the model, then advance the model across the edge.
  task automatic step(input bit ie, input logic [4:0] ia, input bit we,
                      input logic [4:0] wa, input logic [31:0] wd, input bit fl,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0]  ra;
    logic [31:0] exp_d;
    bit          exp_b;
    bit          exp_rdy;
    bit          fire;
    bit          hit;
    int          c;
    @(negedge clk);
    iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
    wr_pc = $urandom; flush = fl; rd_addr = {ra1, ra0};
    #1;
    for (int k = 0; k < NRD; k++) begin
      ra = (k == 0) ? ra0 : ra1;
      if (ra == 0)                exp_d = '0;
      else if (we && wa == ra)    exp_d = wd;
      else                        exp_d = m_regs[ra];
      exp_b = (ra != 0) && (m_cnt[ra] != 0) && !(we && wa == ra && m_cnt[ra] == 1);
      check_val($sformatf("rd_data%0d", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_d));
      check_val($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(exp_b));
    end
    exp_rdy = !(ia != 0 && m_cnt[ia] == MAXC && !(we && wa == ia));
    check_val("iss_ready", 64'(iss_ready), 64'(exp_rdy));
    check_val("err_underflow", 64'(err_underflow), 64'(m_err));
    $display("txn %0d: iss=%b@%0d wr=%b@%0d=%h fl=%b rd=%0d/%0d -> %h/%h busy=%b rdy=%b err=%b",
             n_txn, ie, ia, we, wa, wd, fl, ra0, ra1, rd_data[31:0], rd_data[63:32],
             rd_busy, iss_ready, err_underflow);
    n_txn++;
    // Outstanding count moves by +1 per accepted issue and -1 per
    // write-back. It never goes below zero; an attempt to do so is an
    // underflow.
    fire = ie && exp_rdy && (ia != 0);
    hit  = we && (wa != 0);
    if (hit) m_regs[wa] = wd;
    for (int r = 0; r < DEPTH; r++) begin
      c = m_cnt[r] + ((fire && ia == r) ? 1 : 0) - ((hit && wa == r) ? 1 : 0);
      if (c < 0) begin
        m_err = 1'b1;
        c = 0;
      end
      m_cnt[r] = fl ? 0 : c;
    end
    @(posedge clk);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
           5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 31) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    // Outputs during reset: a pending write must not bypass onto rd_data.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; rd_addr = {5'd5, 5'd5};
    iss_en = 1'b1; iss_addr = 5'd5;
    #1;
    check_val("rst_rd_data", 64'(rd_data), 64'd0);
    check_val("rst_rd_busy", 64'(rd_busy), 64'd0);
    check_val("rst_iss_ready", 64'(iss_ready), 64'd1);
    check_val("rst_err", 64'(err_underflow), 64'd0);
    wr_en = 1'b0; iss_en = 1'b0;
    reset_n = 1'b1;

    // Write with a same-cycle read (bypass), then a read from the stored array.
    step(1, 5'd5, 0, 5'd0, 32'h0, 0, 5'd5, 5'd0);
    step(0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd5);
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd5, 5'd0);
    check_val("r5_stored", 64'(rd_data[31:0]), 64'hDEADBEEF);
    // A write to r0 is ignored.
    step(0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0);
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5);
    // Saturate r3. The 4th issue is refused unless a write to r3 happens
    // in the same cycle.
    repeat (3) step(1, 5'd3, 0, 5'd0, 32'h0, 0, 5'd3, 5'd0);
    step(1, 5'd3, 0, 5'd0, 32'h0, 0, 5'd3, 5'd3);
    check_val("r3_full_refused", 64'(iss_ready), 64'd0);
    step(1, 5'd3, 1, 5'd3, 32'h33, 0, 5'd3, 5'd0);
    // Issue to r7, then write r7 one cycle later.
    step(1, 5'd7, 0, 5'd0, 32'h0, 0, 5'd7, 5'd0);
    step(0, 5'd0, 1, 5'd7, 32'h77, 0, 5'd7, 5'd0);
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd7, 5'd0);
    // Underflow on r9 sets the sticky flag.
    step(0, 5'd0, 1, 5'd9, 32'h99, 0, 5'd9, 5'd0);
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd9, 5'd0);
    check_val("err_sticky", 64'(err_underflow), 64'd1);
    // Same-cycle issue and write at counter 0 is not an underflow.
    step(1, 5'd10, 1, 5'd10, 32'hA0, 0, 5'd10, 5'd0);
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd10, 5'd0);
    // Flush together with a write to r4.
    repeat (2) step(1, 5'd4, 0, 5'd0, 32'h0, 0, 5'd4, 5'd0);
    step(0, 5'd0, 1, 5'd4, 32'h4444, 1, 5'd4, 5'd0);
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd4, 5'd3);

    rand_steps(250);

    // Reset asserted away from any clock edge, with state non-zero.
    repeat (3) step(1, 5'd6, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    @(negedge clk);
    iss_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE; flush = 1'b0;
    rd_addr = {5'd5, 5'd6};
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rd_data", 64'(rd_data), 64'd0);
    check_val("async_rd_busy", 64'(rd_busy), 64'd0);
    check_val("async_iss_ready", 64'(iss_ready), 64'd1);
    check_val("async_err", 64'(err_underflow), 64'd0);
    model_reset();
    wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd5, 5'd6);

    rand_steps(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
